// File: rtl/div_iterative_if.sv
// Handshake and operand bundle between the execute stage and the
// iterative divider. The master side is the EX stage; the slave side is
// the divider itself.
interface div_iterative_if #(
  parameter int WIDTH = 32
);
  logic                 signed_div_input;
  logic [WIDTH-1:0]     dividend_input;
  logic [WIDTH-1:0]     divisor_input;
  logic                 start_input;
  logic                 annul_input;
  logic [2*WIDTH-1:0]   result_output;
  logic                 ready_output;
  logic                 busy_output;

  modport master (
    output signed_div_input, dividend_input, divisor_input,
           start_input, annul_input,
    input  result_output, ready_output, busy_output
  );

  modport slave (
    input  signed_div_input, dividend_input, divisor_input,
           start_input, annul_input,
    output result_output, ready_output, busy_output
  );
endinterface

// File: rtl/div_iterative.sv
// Multi-cycle restoring divider for DIV/DIVU. One quotient bit per cycle;
// result is {remainder, quotient} for the HI/LO write-back. WIDTH >= 2.
module div_iterative #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input logic          clock,
  input logic          reset,
  div_iterative_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ON      = 2'd1,
    BY_ZERO = 2'd2,
    END     = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]   rem_q;      // partial remainder
  logic [WIDTH-1:0]   quo_q;      // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0]   dvs_q;      // divisor magnitude
  logic [CNT_W-1:0]   count_q;
  logic               neg_quo_q;
  logic               neg_rem_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;

  logic               accept;
  logic               busy;
  logic               last_step;

  // Operand conditioning at acceptance: signed operands become magnitudes.
  logic               is_signed;
  logic               dvd_neg;
  logic               dvs_neg;
  logic [WIDTH-1:0]   dvd_mag;
  logic [WIDTH-1:0]   dvs_mag;

  assign is_signed = SIGNED_EN & bus.signed_div_input;
  assign dvd_neg   = is_signed & bus.dividend_input[WIDTH-1];
  assign dvs_neg   = is_signed & bus.divisor_input[WIDTH-1];
  assign dvd_mag   = dvd_neg ? -bus.dividend_input : bus.dividend_input;
  assign dvs_mag   = dvs_neg ? -bus.divisor_input  : bus.divisor_input;

  // One restoring step: shift in the next dividend bit, trial-subtract.
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH-1:0]   step_quo;
  logic [WIDTH-1:0]   fin_rem;
  logic [WIDTH-1:0]   fin_quo;

  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  // Restore or keep the trial difference depending on its sign.
  always_comb begin
    step_rem = shifted[WIDTH-1:0];
    step_quo = {quo_q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      step_rem = trial[WIDTH-1:0];
      step_quo = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  // Sign fix-up: quotient negated on differing signs, remainder follows dividend.
  assign fin_quo = neg_quo_q ? -step_quo : step_quo;
  assign fin_rem = neg_rem_q ? -step_rem : step_rem;

  assign last_step = (count_q == CNT_W'(WIDTH - 1));

  // Next-state decode; annul overrides every other transition.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d = state_q;
    accept  = 1'b0;
    busy    = (state_q == ON) || (state_q == BY_ZERO);
    if (bus.annul_input) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_input) begin
            accept  = 1'b1;
            state_d = (bus.divisor_input == '0) ? BY_ZERO : ON;
          end
        end
        ON:      if (last_step) state_d = END;
        BY_ZERO: state_d = END;
        END:     if (!bus.start_input) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath: latch operands on accept, step while ON, capture result on END entry.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: every register here is a flop with async clear; there is no memory array to leave unreset.
    if (!reset) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      count_q   <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      // ready trails END entry by one cycle, so the result has settled a full
      // cycle before EX can see it, and drops on the same edge END is left.
      ready_q <= (state_q == END) && (state_d == END);

      if (accept) begin
        rem_q     <= '0;
        quo_q     <= dvd_mag;
        dvs_q     <= dvs_mag;
        count_q   <= '0;
        neg_quo_q <= dvd_neg ^ dvs_neg;
        neg_rem_q <= dvd_neg;
      end else if (state_q == ON) begin
        rem_q   <= step_rem;
        quo_q   <= step_quo;
        count_q <= count_q + CNT_W'(1);
      end

      if (state_d != END)      result_q <= '0;
      else if (state_q == ON)  result_q <= {fin_rem, fin_quo};
    end
  end

  assign bus.result_output = result_q;
  assign bus.ready_output  = ready_q;
  assign bus.busy_output   = busy;

endmodule
